// File: rtl/usb_byte_fifo_pkg.sv
// -----------------------------------------------------------------------------
// usb_byte_fifo_pkg
// Shared constants for the USB CDC byte FIFOs and the ACIA top-level glue:
// byte width and the default depth/timeout used when instantiating the FIFO.
// No ports.
// -----------------------------------------------------------------------------
package usb_byte_fifo_pkg;

   localparam int USB_BYTE_W         = 8;
   localparam int USB_FIFO_DEPTH_LOG2 = 4;
   localparam int USB_FIFO_TIMEOUT    = 1024;

endpackage : usb_byte_fifo_pkg

// File: rtl/usb_byte_fifo_mem.sv
// -----------------------------------------------------------------------------
// usb_fifo_mem
// 2**AW x DW storage array, synchronous write, asynchronous read. Kept as its
// own module so the read path can later be retimed onto an iCE40 EBR with a
// registered read without touching the FIFO control logic. Storage is not
// reset.
//
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module usb_fifo_mem
   import usb_byte_fifo_pkg::*;
#(
   parameter int AW = 4,
   parameter int DW = USB_BYTE_W
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [0:(2**AW)-1];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : usb_fifo_mem

// File: rtl/usb_byte_fifo.sv
// -----------------------------------------------------------------------------
// usb_byte_fifo
// Single-clock first-word-fall-through byte FIFO with valid/ready on both
// sides, sitting between the ACIA CPU interface and the MUACM USB CDC core.
// All status outputs come from the registered occupancy count, so there is no
// combinational path from in_val/out_rdy to any output.
//
// Optional feature (macro USB_FIFO_FLUSH_EN): an idle counter raises a
// one-cycle flush pulse after TIMEOUT clocks with data waiting and no new
// push, used to trigger the MUACM short-packet flush. Without the macro the
// flush output is tied low.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   in_data   in   write byte
//   in_val    in   write byte valid
//   in_rdy    out  FIFO can accept (not full)
//   out_data  out  head byte, valid when out_val=1
//   out_val   out  FIFO non-empty
//   out_rdy   in   consumer takes head byte
//   level     out  occupancy 0..2**DEPTH_LOG2
//   full      out  level == 2**DEPTH_LOG2
//   empty     out  level == 0
//   flush     out  one-cycle end-of-burst pulse
// -----------------------------------------------------------------------------
module usb_byte_fifo
   import usb_byte_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = USB_FIFO_DEPTH_LOG2,
   parameter int TIMEOUT    = USB_FIFO_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [USB_BYTE_W-1:0] in_data,
   input  logic                  in_val,
   output logic                  in_rdy,
   output logic [USB_BYTE_W-1:0] out_data,
   output logic                  out_val,
   input  logic                  out_rdy,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  empty,
   output logic                  flush
);

   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  push, pop;

   assign full    = (count_q == DEPTH_CNT);
   assign empty   = (count_q == '0);
   assign in_rdy  = ~full;
   assign out_val = ~empty;
   assign level   = count_q;

   // A pop while full does not open a slot in the same cycle: in_rdy is taken
   // from the registered count only.
   assign push = in_val & in_rdy;
   assign pop  = out_val & out_rdy;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   usb_fifo_mem #(
      .AW (DEPTH_LOG2),
      .DW (USB_BYTE_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (out_data)
   );

`ifdef USB_FIFO_FLUSH_EN
   localparam int              IDLE_W    = $clog2(TIMEOUT) + 1;
   localparam logic [IDLE_W-1:0] IDLE_TERM = IDLE_W'(TIMEOUT);

   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              flush_q, flush_d;

   // Counter restarts on every push, holds while empty, and saturates at the
   // terminal value so only one pulse is produced per burst. The pulse is
   // registered so flush has no path from in_val.
   always_comb begin
      idle_d  = idle_q;
      flush_d = 1'b0;
      if (push) begin
         idle_d = '0;
      end else if (!empty && (idle_q != IDLE_TERM)) begin
         idle_d  = idle_q + 1'b1;
         flush_d = (idle_q == IDLE_TERM - 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_q  <= '0;
         flush_q <= 1'b0;
      end else begin
         idle_q  <= idle_d;
         flush_q <= flush_d;
      end
   end

   assign flush = flush_q;
`else
   assign flush = 1'b0;
`endif

endmodule : usb_byte_fifo
